// File: rtl/bound_interval_reducer.sv
// Streaming max/min reducer: folds one constraint set's lower/upper bound candidates
// into a sampling interval and holds it behind a valid/ready handshake.
module bound_interval_reducer #(
    parameter int NUMBER_SIZE = 4,
    parameter int MAX_TERMS   = 8,
    parameter int COUNT_SIZE  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [NUMBER_SIZE-1:0] in_number,
    input  logic                          in_activation,
    input  logic                          in_is_lower,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [NUMBER_SIZE-1:0] lower_bound,
    output logic                          lower_valid,
    output logic signed [NUMBER_SIZE-1:0] upper_bound,
    output logic                          upper_valid,
    output logic                          feasible,
    output logic                          overflow,
    output logic [COUNT_SIZE-1:0]         term_count
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    // Identity elements of the max and min reductions.
    localparam logic signed [NUMBER_SIZE-1:0] LO_MIN = {1'b1, {(NUMBER_SIZE-1){1'b0}}};
    localparam logic signed [NUMBER_SIZE-1:0] HI_MAX = {1'b0, {(NUMBER_SIZE-1){1'b1}}};
    localparam logic [COUNT_SIZE-1:0]         MAX_CNT = COUNT_SIZE'(MAX_TERMS);

    logic [0:0]                    state;
    logic signed [NUMBER_SIZE-1:0] lo_reg;
    logic signed [NUMBER_SIZE-1:0] hi_reg;
    logic                          lo_act;
    logic                          hi_act;
    logic [COUNT_SIZE-1:0]         count;
    logic                          ovf_reg;

    logic                  beat;
    logic [COUNT_SIZE-1:0] count_nxt;
    logic                  at_max;
    logic                  close;
    logic                  take_lo;
    logic                  take_hi;

    assign in_ready  = (state == ACCUM);
    assign beat      = in_valid & in_ready;
    assign count_nxt = count + COUNT_SIZE'(1);
    assign at_max    = (count_nxt == MAX_CNT);
    assign close     = in_last | at_max;

    // Strict compares keep the stored value on a tie.
    assign take_lo = in_activation &  in_is_lower & (!lo_act || in_number > lo_reg);
    assign take_hi = in_activation & !in_is_lower & (!hi_act || in_number < hi_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ACCUM;
            lo_reg  <= LO_MIN;
            hi_reg  <= HI_MAX;
            lo_act  <= 1'b0;
            hi_act  <= 1'b0;
            count   <= '0;
            ovf_reg <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        count <= count_nxt;
                        if (take_lo) begin
                            lo_reg <= in_number;
                            lo_act <= 1'b1;
                        end
                        if (take_hi) begin
                            hi_reg <= in_number;
                            hi_act <= 1'b1;
                        end
                        if (close) begin
                            state   <= HOLD;
                            ovf_reg <= at_max & !in_last;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state   <= ACCUM;
                        lo_reg  <= LO_MIN;
                        hi_reg  <= HI_MAX;
                        lo_act  <= 1'b0;
                        hi_act  <= 1'b0;
                        count   <= '0;
                        ovf_reg <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign out_valid   = (state == HOLD);
    assign lower_bound = lo_reg;
    assign lower_valid = lo_act;
    assign upper_bound = hi_reg;
    assign upper_valid = hi_act;
    assign feasible    = !(lo_act && hi_act && (lo_reg > hi_reg));
    assign overflow    = ovf_reg;
    assign term_count  = count;

endmodule

// File: tb/tb_bound_interval_reducer.sv
// Directed-vector bench for bound_interval_reducer with hand-computed expected intervals.
module tb_bound_interval_reducer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_number;
    logic       in_activation;
    logic       in_is_lower;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] lower_bound;
    logic       lower_valid;
    logic [3:0] upper_bound;
    logic       upper_valid;
    logic       feasible;
    logic       overflow;
    logic [3:0] term_count;

    int n_checks = 0;
    int n_fail   = 0;

    bound_interval_reducer #(.NUMBER_SIZE(4), .MAX_TERMS(8), .COUNT_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_number(in_number),
        .in_activation(in_activation), .in_is_lower(in_is_lower), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .lower_bound(lower_bound), .lower_valid(lower_valid),
        .upper_bound(upper_bound), .upper_valid(upper_valid),
        .feasible(feasible), .overflow(overflow), .term_count(term_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int n4(input int v);
        logic [3:0] t;
        t = 4'(v);
        return int'(t);
    endfunction

    task automatic send_beat(input int num, input bit act, input bit lower, input bit last);
        @(negedge clk);
        in_valid      = 1'b1;
        in_number     = 4'(num);
        in_activation = act;
        in_is_lower   = lower;
        in_last       = last;
        @(posedge clk);
    endtask

    task automatic expect_result(input string tag, input int lo, input bit lv, input int hi,
                                 input bit hv, input bit fs, input bit ov, input int cnt);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".out_valid"}, int'(out_valid), 1);
        chk({tag, ".in_ready"},  int'(in_ready), 0);
        chk({tag, ".lower_bound"}, int'(lower_bound), n4(lo));
        chk({tag, ".lower_valid"}, int'(lower_valid), int'(lv));
        chk({tag, ".upper_bound"}, int'(upper_bound), n4(hi));
        chk({tag, ".upper_valid"}, int'(upper_valid), int'(hv));
        chk({tag, ".feasible"}, int'(feasible), int'(fs));
        chk({tag, ".overflow"}, int'(overflow), int'(ov));
        chk({tag, ".term_count"}, int'(term_count), cnt);
    endtask

    task automatic expect_empty(input string tag);
        chk({tag, ".in_ready"}, int'(in_ready), 1);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
        chk({tag, ".lower_bound"}, int'(lower_bound), n4(-8));
        chk({tag, ".upper_bound"}, int'(upper_bound), n4(7));
        chk({tag, ".lower_valid"}, int'(lower_valid), 0);
        chk({tag, ".upper_valid"}, int'(upper_valid), 0);
        chk({tag, ".feasible"}, int'(feasible), 1);
        chk({tag, ".overflow"}, int'(overflow), 0);
        chk({tag, ".term_count"}, int'(term_count), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_number = '0; in_activation = 1'b0;
        in_is_lower = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_empty("reset");

        // Mixed set: lower max 1, upper min 4.
        send_beat(-3, 1, 1, 0);
        send_beat( 2, 0, 1, 0);
        send_beat( 1, 1, 1, 0);
        send_beat( 5, 1, 0, 0);
        send_beat(-1, 0, 0, 0);
        send_beat( 4, 1, 0, 1);
        expect_result("mixed", 1, 1, 4, 1, 1, 0, 6);
        @(negedge clk);
        expect_empty("mixed.drain");

        // Infeasible set held under back-pressure.
        out_ready = 1'b0;
        send_beat(6, 1, 1, 0);
        send_beat(3, 1, 0, 1);
        expect_result("infeas", 6, 1, 3, 1, 0, 0, 2);
        @(negedge clk);
        in_valid = 1'b1; in_number = 4'(-2); in_activation = 1'b1;
        in_is_lower = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.in_ready", int'(in_ready), 0);
            chk("bp.out_valid", int'(out_valid), 1);
            chk("bp.lower_bound", int'(lower_bound), 6);
            chk("bp.feasible", int'(feasible), 0);
            chk("bp.term_count", int'(term_count), 2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.release.in_ready", int'(in_ready), 1);
        chk("bp.release.out_valid", int'(out_valid), 0);
        chk("bp.release.term_count", int'(term_count), 0);
        @(posedge clk);
        expect_result("bp.held", -2, 1, 7, 0, 1, 0, 1);

        // One-sided and empty sets.
        send_beat(7, 1, 0, 1);
        expect_result("upper_only", -8, 0, 7, 1, 1, 0, 1);
        send_beat(3, 0, 1, 0);
        send_beat(-5, 0, 0, 0);
        send_beat(1, 0, 1, 1);
        expect_result("inactive", -8, 0, 7, 0, 1, 0, 3);

        // Force-close at MAX_TERMS: lower {-4,-2,0,2}, upper {-3,-1,1,3}.
        for (int i = 0; i < 8; i++) send_beat(i - 4, 1, (i % 2) == 0, 0);
        expect_result("ovf", 2, 1, -3, 1, 0, 1, 8);
        for (int i = 0; i < 8; i++) send_beat(i - 4, 1, (i % 2) == 0, i == 7);
        expect_result("ovf_last", 2, 1, -3, 1, 0, 0, 8);

        // Reset mid-set discards the partial result.
        send_beat(5, 1, 1, 0);
        send_beat(-2, 1, 0, 0);
        send_beat(6, 1, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_empty("midreset");

        // Extremes with ties: lower {-8,-8}, upper {7,-8}.
        send_beat(-8, 1, 1, 0);
        send_beat(-8, 1, 1, 0);
        send_beat(7, 1, 0, 0);
        send_beat(-8, 1, 0, 1);
        expect_result("extremes", -8, 1, -8, 1, 1, 0, 4);
        @(negedge clk);
        expect_empty("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
